branch_mux: RTL and testbench

Branch offset select stage of the 16-bit single-cycle CPU datapath. It forwards the sign-extended branch immediate to the PC adder when a branch is taken, and forces a zero offset otherwise. The select path is purely combinational, so the PC update stays single-cycle. A small clocked side block keeps branch-taken statistics for debug and performance observation.

---
 rtl/branch_mux_pkg.sv | 14 +
 rtl/branch_mux_if.sv | 29 ++
 rtl/branch_stats.sv | 41 ++++
 rtl/branch_mux.sv | 43 ++++
 tb/tb_branch_mux.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_mux_pkg.sv
// Shared CPU datapath package: datapath width and offset type
// used by the immediate decoder, branch offset select and PC adder.
package branch_mux_pkg;

   localparam int CPU_WIDTH = 16;
   localparam int CNT_WIDTH_DEF = 16;

   typedef logic [CPU_WIDTH-1:0] offset_t;

   function automatic logic is_backward(input offset_t off);
      return off[CPU_WIDTH-1];
   endfunction

endpackage

// File: rtl/branch_mux_if.sv
// Branch select bundle between the select stage and its statistics block.
interface branch_mux_if #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
);

   logic [WIDTH-1:0]     inst;
   logic                 sel;
   logic [CNT_WIDTH-1:0] taken_count;
   logic [WIDTH-1:0]     last_offset;
   logic                 last_backward;

   modport master (
      output inst,
      output sel,
      input  taken_count,
      input  last_offset,
      input  last_backward
   );

   modport slave (
      input  inst,
      input  sel,
      output taken_count,
      output last_offset,
      output last_backward
   );

endinterface

// File: rtl/branch_stats.sv
// Taken-branch statistics: wrapping taken counter, last taken offset
// and its sign bit, all cleared by a synchronous active-high reset.
module branch_stats #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   branch_mux_if.slave  bus
);

   logic [CNT_WIDTH-1:0] count_d;
   logic [CNT_WIDTH-1:0] count_q;
   logic [WIDTH-1:0]     offset_d;
   logic [WIDTH-1:0]     offset_q;

   always_comb begin
      count_d  = count_q;
      offset_d = offset_q;
      if (bus.sel) begin
         count_d  = count_q + 1'b1;
         offset_d = bus.inst;
      end
   end

   // Reset wins over a taken branch in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         offset_q <= '0;
      end else begin
         count_q  <= count_d;
         offset_q <= offset_d;
      end
   end

   assign bus.taken_count   = count_q;
   assign bus.last_offset   = offset_q;
   assign bus.last_backward = offset_q[WIDTH-1];

endmodule

// File: rtl/branch_mux.sv
// Branch offset select stage: passes the branch immediate to the PC
// adder when taken, zero otherwise, plus taken-branch statistics.
module branch_mux
   import branch_mux_pkg::*;
#(
   parameter int WIDTH     = CPU_WIDTH,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     Branch_Inst,
   input  logic                 Branch_Sel,
   output logic [WIDTH-1:0]     B_Mux_Out,
   output logic [CNT_WIDTH-1:0] Taken_Count,
   output logic [WIDTH-1:0]     Last_Offset,
   output logic                 Last_Backward
);

   branch_mux_if #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) stats_bus ();

   // Conditional select keeps X/Z on the offset visible downstream.
   assign B_Mux_Out = Branch_Sel ? Branch_Inst : '0;

   assign stats_bus.inst = Branch_Inst;
   assign stats_bus.sel  = Branch_Sel;

   branch_stats #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stats (
      .clk (clk),
      .rst (rst),
      .bus (stats_bus.slave)
   );

   assign Taken_Count   = stats_bus.taken_count;
   assign Last_Offset   = stats_bus.last_offset;
   assign Last_Backward = stats_bus.last_backward;

endmodule

// File: tb/tb_branch_mux.sv
// Directed self-checking bench for branch_mux (16-bit and 4-bit counter).
module tb_branch_mux;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   branch_mux_if #(.WIDTH(16), .CNT_WIDTH(16)) bus ();

   logic [15:0] mux4;
   logic [3:0]  cnt4;
   logic [15:0] off4;
   logic        bw4;

   branch_mux #(.WIDTH(16), .CNT_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .Branch_Inst   (bus.inst),
      .Branch_Sel    (bus.sel),
      .B_Mux_Out     (),
      .Taken_Count   (bus.taken_count),
      .Last_Offset   (bus.last_offset),
      .Last_Backward (bus.last_backward)
   );

   logic [15:0] mux16;
   assign mux16 = (bus.sel) ? bus.inst : 16'h0;

   logic [15:0] dmux;
   branch_mux #(.WIDTH(16), .CNT_WIDTH(16)) dut_m (
      .clk           (clk),
      .rst           (rst),
      .Branch_Inst   (bus.inst),
      .Branch_Sel    (bus.sel),
      .B_Mux_Out     (dmux),
      .Taken_Count   (),
      .Last_Offset   (),
      .Last_Backward ()
   );

   branch_mux #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
      .clk           (clk),
      .rst           (rst),
      .Branch_Inst   (bus.inst),
      .Branch_Sel    (bus.sel),
      .B_Mux_Out     (mux4),
      .Taken_Count   (cnt4),
      .Last_Offset   (off4),
      .Last_Backward (bw4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic s, input logic [15:0] i);
      @(negedge clk);
      rst      = r;
      bus.sel  = s;
      bus.inst = i;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 16'h0000);
      tick();
      tick();
      checks++;
      if (bus.taken_count !== 16'd0 || bus.last_offset !== 16'h0
          || bus.last_backward !== 1'b0) begin
         failures++;
         $display("FAIL reset cnt=%h off=%h bw=%b want 0/0/0",
                  bus.taken_count, bus.last_offset, bus.last_backward);
      end
      checks++;
      if (cnt4 !== 4'd0 || off4 !== 16'h0 || bw4 !== 1'b0) begin
         failures++;
         $display("FAIL reset4 cnt=%h off=%h bw=%b want 0/0/0",
                  cnt4, off4, bw4);
      end
   endtask

   task automatic test_not_taken();
      drive(1'b0, 1'b0, 16'h1234);
      checks++;
      if (dmux !== 16'h0000) begin
         failures++;
         $display("FAIL not_taken_mux got=%h want=0000", dmux);
      end
      tick();
      checks++;
      if (bus.taken_count !== 16'd0 || bus.last_offset !== 16'h0) begin
         failures++;
         $display("FAIL not_taken_stats cnt=%h off=%h want 0/0",
                  bus.taken_count, bus.last_offset);
      end
   endtask

   task automatic test_taken();
      drive(1'b0, 1'b1, 16'h1234);
      checks++;
      if (dmux !== 16'h1234 || mux4 !== 16'h1234) begin
         failures++;
         $display("FAIL taken_mux got=%h/%h want=1234", dmux, mux4);
      end
      tick();
      checks++;
      if (bus.taken_count !== 16'd1 || bus.last_offset !== 16'h1234
          || bus.last_backward !== 1'b0 || cnt4 !== 4'd1) begin
         failures++;
         $display("FAIL taken_stats cnt=%h off=%h bw=%b cnt4=%h want 1/1234/0/1",
                  bus.taken_count, bus.last_offset, bus.last_backward, cnt4);
      end
   endtask

   task automatic test_negative();
      drive(1'b0, 1'b1, 16'hFFFF);
      checks++;
      if (dmux !== 16'hFFFF) begin
         failures++;
         $display("FAIL neg_mux got=%h want=ffff", dmux);
      end
      tick();
      checks++;
      if (bus.taken_count !== 16'd2 || bus.last_offset !== 16'hFFFF
          || bus.last_backward !== 1'b1 || bw4 !== 1'b1) begin
         failures++;
         $display("FAIL neg_stats cnt=%h off=%h bw=%b bw4=%b want 2/ffff/1/1",
                  bus.taken_count, bus.last_offset, bus.last_backward, bw4);
      end
   endtask

   task automatic test_highz();
      logic [15:0] zval;
      zval = 16'hzzzz;
      @(negedge clk);
      bus.inst = zval;
      bus.sel  = 1'b1;
      #1;
      checks++;
      if (dmux !== zval) begin
         failures++;
         $display("FAIL highz_mux got=%h want=zzzz", dmux);
      end
      bus.sel  = 1'b0;
      bus.inst = 16'h5555;
      #1;
      checks++;
      if (dmux !== 16'h0000) begin
         failures++;
         $display("FAIL sel0_mux got=%h want=0000", dmux);
      end
   endtask

   task automatic test_hold();
      drive(1'b0, 1'b0, 16'h5555);
      tick();
      tick();
      checks++;
      if (bus.taken_count !== 16'd2 || bus.last_offset !== 16'hFFFF
          || bus.last_backward !== 1'b1) begin
         failures++;
         $display("FAIL hold cnt=%h off=%h bw=%b want 2/ffff/1",
                  bus.taken_count, bus.last_offset, bus.last_backward);
      end
   endtask

   task automatic test_reset_priority();
      drive(1'b1, 1'b1, 16'h8001);
      checks++;
      if (dmux !== 16'h8001) begin
         failures++;
         $display("FAIL rstprio_mux got=%h want=8001", dmux);
      end
      tick();
      checks++;
      if (bus.taken_count !== 16'd0 || bus.last_offset !== 16'h0
          || bus.last_backward !== 1'b0 || cnt4 !== 4'd0) begin
         failures++;
         $display("FAIL rstprio_stats cnt=%h off=%h bw=%b cnt4=%h want 0/0/0/0",
                  bus.taken_count, bus.last_offset, bus.last_backward, cnt4);
      end
      checks++;
      if (dmux !== 16'h8001) begin
         failures++;
         $display("FAIL rstprio_mux_post got=%h want=8001", dmux);
      end
   endtask

   task automatic test_wrap();
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 1'b1, 16'(i * 16'h0101));
         tick();
         if (i == 15) begin
            checks++;
            if (cnt4 !== 4'd15) begin
               failures++;
               $display("FAIL wrap15 cnt4=%h want=f", cnt4);
            end
         end
      end
      checks++;
      if (cnt4 !== 4'd0 || bus.taken_count !== 16'd16) begin
         failures++;
         $display("FAIL wrap cnt4=%h cnt16=%h want 0/0010",
                  cnt4, bus.taken_count);
      end
      checks++;
      if (off4 !== 16'h1010 || bus.last_offset !== 16'h1010) begin
         failures++;
         $display("FAIL wrap_off off4=%h off16=%h want 1010",
                  off4, bus.last_offset);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.sel  = 1'b0;
      bus.inst = 16'h0;
      test_reset();
      test_not_taken();
      test_taken();
      test_negative();
      test_highz();
      test_hold();
      test_reset_priority();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
